// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StDone
  } state_t;

  localparam logic [2:0] CLS_R     = 3'b000;
  localparam logic [2:0] CLS_BEQ   = 3'b001;
  localparam logic [2:0] CLS_SRL   = 3'b010;
  localparam logic [2:0] CLS_SLL   = 3'b011;
  localparam logic [2:0] CLS_LOAD  = 3'b100;
  localparam logic [2:0] CLS_STORE = 3'b101;
  localparam logic [2:0] CLS_JUMP  = 3'b110;
  localparam logic [2:0] CLS_I     = 3'b111;

  localparam logic [1:0] OPT_HALT = 2'b11;

  localparam int unsigned CLS_MSB = 8;
  localparam int unsigned CLS_LSB = 6;
  localparam int unsigned OPT_MSB = 5;
  localparam int unsigned OPT_LSB = 4;

  function automatic logic is_halt(input logic [2:0] cls, input logic [1:0] opt);
    return (cls == CLS_I) && (opt == OPT_HALT);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: signed-offset branch, increment or hold, all modulo 2^PC_W.
module pc_next #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned OFF_W = 6
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take_branch,
  input  logic             inc,
  output logic [PC_W-1:0]  next_pc
);

  always_comb begin
    // Sign-extend (or truncate) the offset to PC_W; the add then wraps naturally.
    if (take_branch) begin
      next_pc = pc + PC_W'(signed'(offset));
    end else if (inc) begin
      next_pc = pc + PC_W'(1);
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the 9-bit instruction datapath.
// Optional perf counters (cyc_cnt, ret_cnt) are enabled by defining INSTR_SEQ_PERF_CNT_EN.
module instr_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned OFF_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ack,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         alu_op,
  output logic [1:0]         op_type,
  input  logic               alu_zero,
  output logic               mem_re,
  output logic               mem_we,
  output logic               reg_we,
  output logic               busy
`ifdef INSTR_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]        cyc_cnt,
  output logic [15:0]        ret_cnt
`endif
);

  import seq_pkg::*;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d, pc_nxt;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [2:0]           cls;
  logic [1:0]           opt;
  logic                 take, inc, launch;

  assign cls = instr_q[CLS_MSB:CLS_LSB];
  assign opt = instr_q[OPT_MSB:OPT_LSB];

  // PC update control is kept apart from the state logic so pc_nxt never feeds back into it.
  always_comb begin
    take = 1'b0;
    inc  = 1'b0;
    unique case (state_q)
      StExec: begin
        if (cls == CLS_BEQ) begin
          take = alu_zero;
          inc  = ~alu_zero;
        end else if (cls == CLS_JUMP) begin
          take = 1'b1;
        end
      end
      StMem:   inc = (cls == CLS_STORE);
      StWb:    inc = 1'b1;
      default: ;
    endcase
  end

  pc_next #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc          (pc_q),
    .offset      (instr_q[OFF_W-1:0]),
    .take_branch (take),
    .inc         (inc),
    .next_pc     (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          launch  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        instr_d = imem_data;
        state_d = StExec;
      end
      StExec: begin
        unique case (cls)
          CLS_R, CLS_SRL, CLS_SLL: state_d = StWb;
          CLS_I:                   state_d = is_halt(cls, opt) ? StDone : StWb;
          CLS_LOAD, CLS_STORE:     state_d = StMem;
          CLS_BEQ, CLS_JUMP:       state_d = StFetch;
        endcase
      end
      StMem:   state_d = (cls == CLS_LOAD) ? StWb : StFetch;
      StWb:    state_d = StFetch;
      default: state_d = StIdle;
    endcase
    pc_d = launch ? '0 : pc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Moore outputs: decoded from the current state only, so reset kills strobes at once.
  always_comb begin
    ack     = 1'b0;
    busy    = 1'b0;
    alu_op  = 3'b000;
    op_type = 2'b00;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StDone: ack = 1'b1;
      StFetch, StDecode: busy = 1'b1;
      StExec, StMem, StWb: begin
        busy    = 1'b1;
        alu_op  = cls;
        op_type = opt;
        mem_re  = (state_q == StMem) && (cls == CLS_LOAD);
        mem_we  = (state_q == StMem) && (cls == CLS_STORE);
        reg_we  = (state_q == StWb);
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;

`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [15:0] cyc_q, ret_q;
  logic        retire;

  assign retire = ((state_q == StExec || state_q == StMem || state_q == StWb) &&
                   (state_d == StFetch)) || (state_q == StExec && state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (launch) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
      if (retire && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default PC_W plus a PC_W=4 instance for wrap).
module tb_instr_sequencer;

  logic       clk, rst_n, start, start_s, alu_zero;
  logic       ack, busy, mem_re, mem_we, reg_we;
  logic       ack_s, busy_s, mem_re_s, mem_we_s, reg_we_s;
  logic [9:0] imem_addr;
  logic [3:0] imem_addr_s;
  logic [8:0] imem_data, imem_data_s, instr, instr_s;
  logic [2:0] alu_op, alu_op_s;
  logic [1:0] op_type, op_type_s;
`ifdef INSTR_SEQ_PERF_CNT_EN
  logic [15:0] cyc_cnt, ret_cnt, cyc_cnt_s, ret_cnt_s;
`endif

  logic [8:0] rom   [1024];
  logic [8:0] rom_s [16];

  int checks = 0;
  int errors = 0;

  instr_sequencer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ack       (ack),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .instr     (instr),
    .alu_op    (alu_op),
    .op_type   (op_type),
    .alu_zero  (alu_zero),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .reg_we    (reg_we),
    .busy      (busy)
`ifdef INSTR_SEQ_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt)
`endif
  );

  instr_sequencer #(
    .PC_W (4)
  ) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .ack       (ack_s),
    .imem_addr (imem_addr_s),
    .imem_data (imem_data_s),
    .instr     (instr_s),
    .alu_op    (alu_op_s),
    .op_type   (op_type_s),
    .alu_zero  (alu_zero),
    .mem_re    (mem_re_s),
    .mem_we    (mem_we_s),
    .reg_we    (reg_we_s),
    .busy      (busy_s)
`ifdef INSTR_SEQ_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt_s),
    .ret_cnt   (ret_cnt_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    imem_data   <= rom[imem_addr];
    imem_data_s <= rom_s[imem_addr_s];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; alu_zero = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h1F0;
    for (int i = 0; i < 16; i++) rom_s[i] = 9'h1F0;
    tick(2);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_op_type", 32'(op_type), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    rst_n = 1'b1;

    // R add then HALT
    rom[0] = 9'h000; rom[1] = 9'h1F0;
    start = 1'b1; tick(1); start = 1'b0;           // c1 FETCH
    chk("r_busy_fetch", 32'(busy), 1);
    chk("r_addr0", 32'(imem_addr), 0);
    tick(2);                                        // c3 EXEC
    chk("r_no_we_exec", 32'(reg_we), 0);
    tick(1);                                        // c4 WB
    chk("r_reg_we_c4", 32'(reg_we), 1);
    tick(1);                                        // c5 FETCH pc=1
    chk("r_reg_we_drop", 32'(reg_we), 0);
    chk("r_addr1", 32'(imem_addr), 1);
    tick(2);                                        // c7 EXEC HALT
    chk("halt_alu_op", 32'(alu_op), 7);
    chk("halt_op_type", 32'(op_type), 3);
    tick(1);                                        // c8 DONE
    chk("done_ack", 32'(ack), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_pc", 32'(imem_addr), 1);
    chk("done_alu_op", 32'(alu_op), 0);
    tick(1);
    chk("done_hold_ack", 32'(ack), 1);

    // LOAD, STORE, HALT
    rom[0] = 9'h101; rom[1] = 9'h142; rom[2] = 9'h1F0;
    start = 1'b1; tick(1); start = 1'b0;           // c1
    chk("ls_ack_fall", 32'(ack), 0);
    tick(2);                                        // c3 EXEC LOAD
    chk("ld_alu_op", 32'(alu_op), 4);
    tick(1);                                        // c4 MEM
    chk("ld_mem_re", 32'(mem_re), 1);
    chk("ld_no_mem_we", 32'(mem_we), 0);
    tick(1);                                        // c5 WB
    chk("ld_reg_we", 32'(reg_we), 1);
    chk("ld_mem_re_drop", 32'(mem_re), 0);
    tick(1);                                        // c6 FETCH
    chk("ld_next_addr", 32'(imem_addr), 1);
    tick(2);                                        // c8 EXEC STORE
    chk("st_alu_op", 32'(alu_op), 5);
    chk("st_instr", 32'(instr), 32'h142);
    tick(1);                                        // c9 MEM
    chk("st_mem_we", 32'(mem_we), 1);
    chk("st_no_reg_we", 32'(reg_we), 0);
    tick(1);                                        // c10 FETCH
    chk("st_mem_we_drop", 32'(mem_we), 0);
    chk("st_next_addr", 32'(imem_addr), 2);
    tick(3);                                        // c13 DONE
    chk("ls_done_ack", 32'(ack), 1);
    chk("ls_done_pc", 32'(imem_addr), 2);

    // BEQ -2 at pc=5, taken then not taken; start held through DONE relaunches
    rom[0] = 9'h185; rom[5] = 9'h07E; rom[1] = 9'h1F0; rom[2] = 9'h1F0;
    start = 1'b1; tick(1); start = 1'b0;           // c1
    tick(3);                                        // c4 FETCH pc=5
    chk("jmp_addr5", 32'(imem_addr), 5);
    tick(2);                                        // c6 EXEC BEQ
    chk("beq_alu_op", 32'(alu_op), 1);
    alu_zero = 1'b1;
    tick(1);                                        // c7
    alu_zero = 1'b0;
    chk("beq_taken", 32'(imem_addr), 3);
    tick(2);                                        // c9 EXEC HALT
    start = 1'b1;
    tick(1);                                        // c10 DONE
    chk("relaunch_ack", 32'(ack), 1);
    chk("relaunch_pc", 32'(imem_addr), 3);
    tick(1);                                        // c11 FETCH
    start = 1'b0;
    chk("relaunch_ack_fall", 32'(ack), 0);
    chk("relaunch_busy", 32'(busy), 1);
    chk("relaunch_addr0", 32'(imem_addr), 0);
    tick(6);                                        // c17
    chk("beq_not_taken", 32'(imem_addr), 6);
    tick(3);                                        // c20 DONE
    chk("beq_nt_done", 32'(ack), 1);

    // Wrap: JUMP -1 from 0, ADDI at top of space; PC_W=4 JUMP +1 and ADDI at 15
    rom[0] = 9'h1BF; rom[1023] = 9'h1C1;
    rom_s[0] = 9'h1BF; rom_s[15] = 9'h181;
    start = 1'b1; start_s = 1'b1; tick(1); start = 1'b0; start_s = 1'b0;
    tick(3);                                        // c4
    chk("wrap_neg_main", 32'(imem_addr), 1023);
    chk("wrap_neg_small", 32'(imem_addr_s), 15);
    tick(3);                                        // c7
    chk("wrap_addi_we", 32'(reg_we), 1);
    chk("wrap_jump_small", 32'(imem_addr_s), 0);
    tick(1);                                        // c8
    chk("wrap_addi_main", 32'(imem_addr), 0);
    rom_s[15] = 9'h1C1;
    tick(2);                                        // c10
    chk("wrap_small_15", 32'(imem_addr_s), 15);
    tick(4);                                        // c14
    chk("wrap_addi_small", 32'(imem_addr_s), 0);
    rst_n = 1'b0; tick(1);
    chk("wrap_rst_busy", 32'(busy), 0);
    chk("wrap_rst_busy_s", 32'(busy_s), 0);
    rst_n = 1'b1;

    // start ignored in EXEC, async reset during WB
    rom[0] = 9'h000; rom[1] = 9'h1F0;
    start = 1'b1; tick(1); start = 1'b0;           // c1
    tick(2);                                        // c3 EXEC
    start = 1'b1;
    tick(1);                                        // c4 WB
    start = 1'b0;
    chk("ign_reg_we", 32'(reg_we), 1);
    chk("ign_pc", 32'(imem_addr), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reg_we", 32'(reg_we), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_instr", 32'(instr), 0);
    tick(1); rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", 32'(busy), 0);

`ifdef INSTR_SEQ_PERF_CNT_EN
    // R, LOAD, HALT: 4 + 5 + 3 busy cycles, three retirements
    rom[0] = 9'h000; rom[1] = 9'h101; rom[2] = 9'h1F0;
    start = 1'b1; tick(1); start = 1'b0;
    chk("perf_cyc_clear", 32'(cyc_cnt), 0);
    tick(12);                                       // c13 DONE
    chk("perf_done", 32'(ack), 1);
    chk("perf_ret", 32'(ret_cnt), 3);
    chk("perf_cyc", 32'(cyc_cnt), 12);
    tick(1);
    chk("perf_cyc_hold", 32'(cyc_cnt), 12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
